// File: rtl/display_pkg.sv
// Shared constants for the multiplexed seven-segment display path.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package display_pkg;

   localparam int MAX_DIGITS = 8;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment glyph; non-decimal codes show a dash.
module seg7_decode
   import display_pkg::*;
(
   input  logic [3:0] val_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      unique case (val_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/scan_display_ctrl.sv
// Multiplexed seven-segment scanner with per-frame source snapshot and blinking.
// Optional leading-zero blanking is enabled by defining SCAN_DISPLAY_LZ_BLANK_EN.
module scan_display_ctrl
   import display_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int NUM_SRC    = 5,
   parameter int SCAN_DIV   = 100000,
   parameter int BLINK_DIV  = 50000000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_SRC*NUM_DIGITS*4-1:0] src_digits,
   input  logic [NUM_SRC-1:0]              src_en,
   input  logic [NUM_DIGITS-1:0]           blink_mask,
   output logic [6:0]                      seg,
   output logic [NUM_DIGITS-1:0]           anodes,
   output logic                            frame_start
);

   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = $clog2(BLINK_DIV);
   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam int SEL_W   = $clog2(NUM_SRC);
   localparam int FRAME_W = NUM_DIGITS * 4;

   logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
   logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
   logic                  phase_q, phase_d;
   logic [IDX_W-1:0]      digit_q, digit_d;
   logic                  run_q, run_d;
   logic [FRAME_W-1:0]    frame_q, frame_d;
   logic [NUM_DIGITS-1:0] mask_q, mask_d;
   logic [6:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
   logic                  fs_q, fs_d;

   logic                  tick, wrap, blank;
   logic [SEL_W-1:0]      sel;
   logic [FRAME_W-1:0]    src_frame;
   logic [NUM_DIGITS-1:0] lz_blank;
   logic [3:0]            cur_val;
   logic [6:0]            dec_seg;
`ifdef SCAN_DISPLAY_LZ_BLANK_EN
   logic                  lead;
`endif

   // Bit 0 of src_en carries no meaning: source 0 is the fallback.
   logic unused_src_en0;
   assign unused_src_en0 = src_en[0];

   seg7_decode u_dec (
      .val_i (cur_val),
      .seg_o (dec_seg)
   );

   always_comb begin
      tick = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
      // run_q is clear until the first tick after reset, forcing a fresh frame.
      wrap = tick && (!run_q || (digit_q == IDX_W'(NUM_DIGITS - 1)));

      scan_cnt_d  = tick ? '0 : scan_cnt_q + SCAN_W'(1);
      run_d       = run_q | tick;
      blink_cnt_d = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) ? '0 : blink_cnt_q + BLINK_W'(1);
      phase_d     = phase_q ^ (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));

      sel = '0;
      for (int s = NUM_SRC - 1; s >= 1; s--) begin
         if (src_en[s]) sel = SEL_W'(s);
      end
      src_frame = src_digits[FRAME_W-1:0];
      for (int s = 0; s < NUM_SRC; s++) begin
         if (sel == SEL_W'(s)) src_frame = src_digits[s*FRAME_W +: FRAME_W];
      end

      frame_d = frame_q;
      mask_d  = mask_q;
      digit_d = digit_q;
      if (wrap) begin
         frame_d = src_frame;
         mask_d  = blink_mask;
         digit_d = '0;
      end else if (tick) begin
         digit_d = digit_q + IDX_W'(1);
      end

      lz_blank = '0;
`ifdef SCAN_DISPLAY_LZ_BLANK_EN
      lead = 1'b1;
      for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
         lead        = lead && (frame_d[d*4 +: 4] == 4'd0);
         lz_blank[d] = lead;
      end
`endif

      // Output is built from next-state values so it lands one clock after the tick.
      cur_val = frame_d[int'(digit_d)*4 +: 4];
      blank   = (phase_d && mask_d[digit_d]) || lz_blank[digit_d];

      seg_d    = seg_q;
      anodes_d = anodes_q;
      fs_d     = wrap;
      if (tick) begin
         seg_d    = blank ? SEG_BLANK : dec_seg;
         anodes_d = blank ? '1 : ~(NUM_DIGITS'(1) << digit_d);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_cnt_q  <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         digit_q     <= '0;
         run_q       <= 1'b0;
         frame_q     <= '0;
         mask_q      <= '0;
         seg_q       <= SEG_BLANK;
         anodes_q    <= '1;
         fs_q        <= 1'b0;
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         digit_q     <= digit_d;
         run_q       <= run_d;
         frame_q     <= frame_d;
         mask_q      <= mask_d;
         seg_q       <= seg_d;
         anodes_q    <= anodes_d;
         fs_q        <= fs_d;
      end
   end

   assign seg         = seg_q;
   assign anodes      = anodes_q;
   assign frame_start = fs_q;

endmodule

// File: doc/scan_display_ctrl.md
SCAN_DISPLAY_CTRL -- requirements
Module: scan_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed seven-segment digits (2..8).
REQ-002 Parameter NUM_SRC, default 5: number of selectable digit sources (2..8); source 0 is the default clock-time source.
REQ-003 Parameter SCAN_DIV, default 100000: clocks per digit dwell (>=2).
REQ-004 Parameter BLINK_DIV, default 50000000: clocks per blink half-period (>=2).
REQ-005 clk  input  1  system clock; the block has one clock, and reset is asynchronous and active-low.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 src_digits  input  NUM_SRC*NUM_DIGITS*4  BCD digits; source s, digit d at bits [(s*NUM_DIGITS+d)*4 +: 4].
REQ-008 src_en  input  NUM_SRC  mode enables; bit 0 is ignored.
REQ-009 blink_mask  input  NUM_DIGITS  per-digit blink request.
REQ-010 seg  output  7  segments {g..a}, active-low, registered.
REQ-011 anodes  output  NUM_DIGITS  digit enables, active-low, registered.
REQ-012 frame_start  output  1  one-clock pulse when digit 0 begins a new frame.

Function
REQ-013 Scan counter: counts 0..SCAN_DIV-1 and issues a tick on the terminal count; each tick advances digit index 0..NUM_DIGITS-1, which wraps to 0.
REQ-014 Frame snapshot: on the tick that wraps to digit 0, the selected source's NUM_DIGITS digits and the blink_mask are latched into a frame buffer; input changes mid-frame have no effect until the next frame.
REQ-015 Source select: lowest-indexed set bit of src_en[NUM_SRC-1:1] wins; if none is set, source 0 is selected; simultaneous enables resolve by the same rule.
REQ-016 Blink: free-running counter toggles blink_phase every BLINK_DIV clocks; while blink_phase=1, digits with a latched mask bit are blanked.
REQ-017 Blanked digit: its anode is held high, and seg=7'h7F.
REQ-018 Decode: values 0-9 map to standard active-low glyphs; values 10-15 map to '-' (seg=7'b0111111).
REQ-019 Latency: seg and anodes update together exactly 1 clock after the tick; frame_start is asserted in that same cycle.
REQ-020 At most one anode bit is low in any cycle, and no intermediate anode/seg combinations are ever driven.

Reset
REQ-021 While reset=0: seg=7'h7F, anodes all 1, frame_start=0, scan/blink counters=0, digit index=0, blink_phase=0, frame buffer zeroed.
REQ-022 Reset asserted mid-frame takes effect immediately (asynchronous); after release, the first tick starts a fresh frame at digit 0 with a new snapshot.

Configuration
REQ-023 Macro SCAN_DISPLAY_LZ_BLANK_EN: when defined, leading zero digits (from digit NUM_DIGITS-1 downward, stopping before digit 0) of the latched frame are blanked as in REQ-017; when undefined, all zeros are displayed.

Structure
REQ-024 Package display_pkg holds the seg7 glyph constants (0-9, dash, blank) and a max digit-count constant.
REQ-025 Sub-module seg7_decode (4-bit in, 7-bit active-low out, combinational) is instantiated once on the scan path.

Verification
Bench parameters: NUM_DIGITS=4, NUM_SRC=5, SCAN_DIV=4, BLINK_DIV=64.
REQ-026 Scenario 1: src_en=0, source 0 digits {5,4,3,2} (d3..d0) -> anodes cycle 1110,1101,1011,0111 every 4 clocks; seg shows 2,3,4,5; frame_start pulses every 16 clocks.
REQ-027 Scenario 2: src_en=5'b00110 -> source 1 is displayed from the next frame; source 1 changed mid-frame -> the old values persist until the next frame_start.
REQ-028 Scenario 3: blink_mask=4'b0011 -> digits 0 and 1 are blanked (anode high, seg=7F) during alternate 64-clock windows; digits 2 and 3 are always lit.
REQ-029 Scenario 4: digit value 4'hC -> seg=7'b0111111; with SCAN_DISPLAY_LZ_BLANK_EN defined, digits {0,0,0,7} -> only digit 0 lit; digits {0,0,0,0} -> only digit 0 lit, showing 0.
REQ-030 Scenario 5: reset pulled low during digit 2 -> outputs are at reset values on the same edge; after release, the first tick produces anodes=1110 and frame_start=1.
REQ-031 All scenarios: assert each cycle that anodes has at most one 0 bit.
